mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read memory between requester 0 (core) and requester 1.
// Ports: clk/reset; m0_*/m1_* request side (req, we, adr, wd in; gnt, rd out); mem_* memory side; arb_state debug.
// Grant is registered from state (req at t -> gnt at t+1); round-robin on ties, owner capped at MAXHOLD cycles when contested.
module mem_arbiter #(
  parameter int N       = 32,
  parameter int MAXHOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [N-1:0] m0_adr,
  input  logic [N-1:0] m0_wd,
  output logic         m0_gnt,
  output logic [N-1:0] m0_rd,
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [N-1:0] m1_adr,
  input  logic [N-1:0] m1_wd,
  output logic         m1_gnt,
  output logic [N-1:0] m1_rd,
  output logic         mem_we,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wd,
  input  logic [N-1:0] mem_rd,
  output logic [1:0]   arb_state
);

  localparam int HW = $clog2(MAXHOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] holdcnt;
  logic          last;       // requester that most recently took ownership
  logic          hold_done;

  assign hold_done = (holdcnt == HOLD_LAST);

  // Next-state: an owner keeps the memory until it lets go, or until its
  // contested budget runs out; handover between owners is direct.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req)                 state_nxt = m1_req ? OWN1 : IDLE;
        else if (m1_req && hold_done) state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_req)                 state_nxt = m0_req ? OWN0 : IDLE;
        else if (m0_req && hold_done) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      holdcnt <= '0;
      last    <= 1'b1;        // makes requester 0 win the first tie
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        holdcnt <= '0;
        if (state_nxt == OWN0) last <= 1'b0;
        if (state_nxt == OWN1) last <= 1'b1;
      end else if (state != IDLE && !hold_done) begin
        holdcnt <= holdcnt + HW'(1);
      end
    end
  end

  assign m0_gnt    = (state == OWN0);
  assign m1_gnt    = (state == OWN1);
  assign arb_state = state;

  // Datapath steering; reset gates the write strobe so a reset cycle never writes.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    m0_rd   = '0;
    m1_rd   = '0;
    case (state)
      OWN0: begin
        mem_adr = m0_adr;
        mem_wd  = m0_wd;
        mem_we  = m0_req & m0_we & ~reset;
        m0_rd   = mem_rd;
      end
      OWN1: begin
        mem_adr = m1_adr;
        mem_wd  = m1_wd;
        mem_we  = m1_req & m1_we & ~reset;
        m1_rd   = mem_rd;
      end
      default: ;
    endcase
  end

endmodule
